// File: rtl/ipsxe_floating_point_div_mul_stage_if.sv
// ipsxe_floating_point_div_mul_stage_if: stream bus of the divider multiply stage.
// Input beat (dividend, reciprocal, upstream flags) and output beat (quotient, flags), each with valid/ready.
interface ipsxe_floating_point_div_mul_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] recip;
    logic             div_by_zero;
    logic             recip_underflow;
    logic             s_tvalid;
    logic             s_tready;
    logic [WIDTH-1:0] quotient;
    logic             m_tvalid;
    logic             m_tready;
    logic             overflow;
    logic             underflow;
    logic             divide_by_zero;
    logic             invalid_op;
    modport slave (
        input  dividend, recip, div_by_zero, recip_underflow, s_tvalid, m_tready,
        output s_tready, quotient, m_tvalid, overflow, underflow, divide_by_zero, invalid_op
    );
    modport master (
        output dividend, recip, div_by_zero, recip_underflow, s_tvalid, m_tready,
        input  s_tready, quotient, m_tvalid, overflow, underflow, divide_by_zero, invalid_op
    );
endinterface

// File: rtl/ipsxe_floating_point_div_mul_stage.sv
// ipsxe_floating_point_div_mul_stage: q = a * (1/b), 3-stage binary32 back-end of the LUT reciprocal divider.
// Define IPSXE_FLT_DIV_ROUND_NEAREST_EN for round-to-nearest-even; default truncates and saturates overflow.
module ipsxe_floating_point_div_mul_stage #(
    parameter int WIDTH  = 32,
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int BIAS   = 127
) (
    input logic i_clk,
    input logic i_areset_n,
    input logic i_aclken,
    ipsxe_floating_point_div_mul_stage_if.slave bus
);
    localparam int MW = FRAC_W + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [WIDTH-1:0] QNAN = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_DBZ, SP_INF, SP_ZERO} special_e;

    logic                 advance;
    logic                 v1_q, v2_q, v3_q, s1_q, s2_q;
    special_e             sp1_d, sp1_q, sp2_q;
    logic [PW-1:0]        prod1_d, prod1_q;
    logic signed [EW-1:0] exp1_d, exp1_q, exp2_d, exp2_q, exp_n;
    logic [FRAC_W-1:0]    frac2_d, frac2_q;
    logic [MW-1:0]        mant;
    logic                 hi, ovf, unf, unused_bits;
    logic [EXP_W-1:0]     ea, er;
    logic [FRAC_W-1:0]    fa, fr;
    logic                 a_zero, a_inf, a_nan;
    logic [WIDTH-1:0]     inf, sat, res, q3_d, q3_q;
    logic [3:0]           flg, flg3_d, flg3_q;

    assign advance      = i_aclken & (~v3_q | bus.m_tready);
    assign bus.s_tready = advance;
    assign {ea, fa}     = bus.dividend[WIDTH-2:0];
    assign {er, fr}     = bus.recip[WIDTH-2:0];

    always_comb begin
        a_zero  = ea == '0;
        a_inf   = ea == EMAX && fa == '0;
        a_nan   = ea == EMAX && fa != '0;
        sp1_d   = (a_nan || (a_zero && bus.div_by_zero) || (a_inf && bus.recip_underflow)) ? SP_NAN :
                  (bus.div_by_zero && !a_inf) ? SP_DBZ :
                  a_inf ? SP_INF :
                  (a_zero || bus.recip_underflow) ? SP_ZERO : SP_NONE;
        prod1_d = {{MW{1'b0}}, 1'b1, fa} * {{MW{1'b0}}, 1'b1, fr};
        exp1_d  = EW'(ea) + EW'(er) - EW'(BIAS);
    end

`ifdef IPSXE_FLT_DIV_ROUND_NEAREST_EN
    logic          g, rb, st;
    logic [MW:0]   sum;
    always_comb begin
        hi      = prod1_q[PW-1];
        mant    = hi ? prod1_q[PW-1 -: MW] : prod1_q[PW-2 -: MW];
        exp_n   = exp1_q + EW'(hi);
        g       = hi ? prod1_q[PW-MW-1] : prod1_q[PW-MW-2];
        rb      = hi ? prod1_q[PW-MW-2] : prod1_q[PW-MW-3];
        st      = hi ? |prod1_q[PW-MW-3:0] : |prod1_q[PW-MW-4:0];
        sum     = {1'b0, mant} + {{MW{1'b0}}, g & (rb | st | mant[0])};
        frac2_d = sum[FRAC_W-1:0];
        exp2_d  = exp_n + EW'(sum[MW]);
    end
    // a carry-out wraps the fraction to zero, which is exactly mantissa 1.0
    assign unused_bits = sum[MW-1];
    assign sat = {s2_q, EMAX, {FRAC_W{1'b0}}};
`else
    always_comb begin
        hi      = prod1_q[PW-1];
        mant    = hi ? prod1_q[PW-1 -: MW] : prod1_q[PW-2 -: MW];
        exp_n   = exp1_q + EW'(hi);
        frac2_d = mant[FRAC_W-1:0];
        exp2_d  = exp_n;
    end
    assign unused_bits = ^{mant[MW-1], prod1_q[PW-MW-2:0]};
    assign sat = {s2_q, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
`endif

    always_comb begin
        ovf    = !exp2_q[EW-1] && exp2_q[EW-2:0] >= {1'b0, EMAX};
        unf    = exp2_q[EW-1] || exp2_q == '0;
        inf    = {s2_q, EMAX, {FRAC_W{1'b0}}};
        res    = sp2_q == SP_NAN ? QNAN :
                 (sp2_q == SP_DBZ || sp2_q == SP_INF) ? inf :
                 sp2_q == SP_ZERO ? {s2_q, {(WIDTH-1){1'b0}}} :
                 ovf ? sat :
                 unf ? {s2_q, {(WIDTH-1){1'b0}}} : {s2_q, exp2_q[EXP_W-1:0], frac2_q};
        flg    = {sp2_q == SP_NONE && ovf, sp2_q == SP_NONE && unf, sp2_q == SP_DBZ, sp2_q == SP_NAN};
        q3_d   = v2_q ? res : '0;
        flg3_d = v2_q ? flg : '0;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            v1_q    <= 1'b0;
            s1_q    <= 1'b0;
            sp1_q   <= SP_NONE;
            prod1_q <= '0;
            exp1_q  <= '0;
            v2_q    <= 1'b0;
            s2_q    <= 1'b0;
            sp2_q   <= SP_NONE;
            exp2_q  <= '0;
            frac2_q <= '0;
            v3_q    <= 1'b0;
            q3_q    <= '0;
            flg3_q  <= '0;
        end else if (advance) begin
            v1_q    <= bus.s_tvalid;
            s1_q    <= bus.dividend[WIDTH-1] ^ bus.recip[WIDTH-1];
            sp1_q   <= sp1_d;
            prod1_q <= prod1_d;
            exp1_q  <= exp1_d;
            v2_q    <= v1_q;
            s2_q    <= s1_q;
            sp2_q   <= sp1_q;
            exp2_q  <= exp2_d;
            frac2_q <= frac2_d;
            v3_q    <= v2_q;
            q3_q    <= q3_d;
            flg3_q  <= flg3_d;
        end
    end

    assign bus.m_tvalid       = v3_q;
    assign bus.quotient       = q3_q;
    assign bus.overflow       = flg3_q[3];
    assign bus.underflow      = flg3_q[2];
    assign bus.divide_by_zero = flg3_q[1];
    assign bus.invalid_op     = flg3_q[0];
endmodule

// File: tb/tb_ipsxe_floating_point_div_mul_stage.sv
// tb_ipsxe_floating_point_div_mul_stage: directed and random beats against an integer-arithmetic reference model.
// Expected words are {overflow, underflow, divide_by_zero, invalid_op, quotient}.
module tb_ipsxe_floating_point_div_mul_stage;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] r;
        logic        dbz;
        logic        run;
        logic [35:0] e;
    } beat_t;

    logic clk, rst_n, aclken;
    int n_cmp = 0, n_err = 0, n_out = 0;
    logic [35:0] sb[$];
    beat_t pend[$];
    logic [35:0] cur_exp, held_v;
    bit held = 0;
    bit acc, ov;
    int lat;

    ipsxe_floating_point_div_mul_stage_if bus ();
    ipsxe_floating_point_div_mul_stage dut (
        .i_clk(clk), .i_areset_n(rst_n), .i_aclken(aclken), .bus(bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(string tag, logic [63:0] o, logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [35:0] obs();
        return {bus.overflow, bus.underflow, bus.divide_by_zero, bus.invalid_op, bus.quotient};
    endfunction

    function automatic logic [35:0] model(logic [31:0] a, logic [31:0] r, logic dbz, logic run);
        logic s = a[31] ^ r[31];
        int ea = int'(a[30:23]);
        int er = int'(r[30:23]);
        bit az = ea == 0;
        bit ai = ea == 255 && a[22:0] == 0;
        bit an = ea == 255 && a[22:0] != 0;
        longint p, m, rem, half;
        int sh, e;
        if (an || (az && dbz) || (ai && run)) return {4'b0001, 32'h7FC00000};
        if (dbz && !ai) return {4'b0010, s, 8'hFF, 23'h0};
        if (ai) return {4'b0000, s, 8'hFF, 23'h0};
        if (az || run) return {4'b0000, s, 31'h0};
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, r[22:0]});
        sh = (p >= (longint'(1) << 47)) ? 24 : 23;
        e = ea + er - 127 + sh - 23;
        m = p >> sh;
`ifdef IPSXE_FLT_DIV_ROUND_NEAREST_EN
        rem = p - (m << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && m[0])) m++;
        if (m == (longint'(1) << 24)) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {4'b1000, s, 8'hFF, 23'h0};
`else
        rem = 0;
        half = 0;
        if (e >= 255) return {4'b1000, s, 8'hFE, 23'h7FFFFF};
`endif
        if (e <= 0) return {4'b0100, s, 31'h0};
        return {4'b0000, s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [7:0] e = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(90, 164));
        logic [22:0] f = ($urandom_range(7) == 0) ? 23'h7FFFFF : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    task automatic add(logic [31:0] a, logic [31:0] r, logic dbz, logic run, logic [35:0] e);
        pend.push_back('{a, r, dbz, run, e});
    endtask

    task automatic add_rand(int n);
        logic [31:0] a, r;
        logic dbz, run;
        for (int i = 0; i < n; i++) begin
            a = rnd_f();
            r = rnd_f();
            dbz = $urandom_range(15) == 0;
            run = $urandom_range(15) == 0;
            add(a, r, dbz, run, model(a, r, dbz, run));
        end
    endtask

    // samples at the falling edge, returns just after the next rising edge
    task automatic tick(output bit a_o, output bit v_o);
        logic [35:0] o;
        @(negedge clk);
        o = obs();
        a_o = bus.s_tvalid && bus.s_tready;
        v_o = bus.m_tvalid;
        check("s_tready", bus.s_tready, aclken && (!bus.m_tvalid || bus.m_tready));
        if (v_o && held) check("stall_hold", o, held_v);
        if (!v_o) check("idle_flags", o[35:32], 0);
        if (v_o && bus.m_tready && aclken) begin
            if (sb.size() == 0) check("extra_beat", v_o, 0);
            else check($sformatf("result#%0d", n_out++), o, sb.pop_front());
        end
        held = v_o && !(bus.m_tready && aclken);
        held_v = o;
        if (a_o) sb.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int lo, int hi, bit rnd, int lim, bit full);
        bit a_t, v_t;
        beat_t b;
        int cyc = 0;
        while ((pend.size() != 0 || sb.size() != 0) && cyc < lim) begin
            bus.s_tvalid = pend.size() != 0;
            if (pend.size() != 0) begin
                b = pend[0];
                bus.dividend = b.a;
                bus.recip = b.r;
                bus.div_by_zero = b.dbz;
                bus.recip_underflow = b.run;
                cur_exp = b.e;
            end
            bus.m_tready = rnd ? ($urandom_range(3) != 0) : !(cyc >= lo && cyc <= hi);
            aclken = rnd ? ($urandom_range(3) != 0) : 1'b1;
            tick(a_t, v_t);
            if (a_t) void'(pend.pop_front());
            cyc++;
        end
        if (full) check("drain_left", 64'(pend.size() + sb.size()), 0);
        bus.s_tvalid = 0;
        bus.m_tready = 1;
        aclken = 1;
    endtask

    initial begin
        rst_n = 0;
        aclken = 1;
        bus.s_tvalid = 0;
        bus.m_tready = 1;
        bus.dividend = 0;
        bus.recip = 0;
        bus.div_by_zero = 0;
        bus.recip_underflow = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.m_tvalid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_flags", obs() >> 32, 0);
        rst_n = 1;
        #1;
        check("rst_ready", bus.s_tready, 1);

        bus.dividend = 32'h40C00000;
        bus.recip = 32'h3F000000;
        cur_exp = {4'b0000, 32'h40400000};
        bus.s_tvalid = 1;
        tick(acc, ov);
        check("first_accept", acc, 1);
        bus.s_tvalid = 0;
        lat = 0;
        do begin
            tick(acc, ov);
            lat++;
        end while (!ov && lat < 10);
        check("latency", lat, 3);

        add(32'hC0C00000, 32'h3F000000, 0, 0, {4'b0000, 32'hC0400000});
`ifdef IPSXE_FLT_DIV_ROUND_NEAREST_EN
        add(32'h3FC00001, 32'h3FC00001, 0, 0, {4'b0000, 32'h40100002});
        add(32'h7F000000, 32'h40000000, 0, 0, {4'b1000, 32'h7F800000});
`else
        add(32'h3FC00001, 32'h3FC00001, 0, 0, {4'b0000, 32'h40100001});
        add(32'h7F000000, 32'h40000000, 0, 0, {4'b1000, 32'h7F7FFFFF});
`endif
        add(32'h00800000, 32'h3F000000, 0, 0, {4'b0100, 32'h00000000});
        add(32'h3F800000, 32'h3F800000, 1, 0, {4'b0010, 32'h7F800000});
        add(32'h00000000, 32'h3F800000, 1, 0, {4'b0001, 32'h7FC00000});
        add(32'h7FC12345, 32'h3F800000, 0, 0, {4'b0001, 32'h7FC00000});
        add(32'hFF800000, 32'h3F800000, 0, 0, {4'b0000, 32'hFF800000});
        add(32'h7F800000, 32'h00000000, 0, 1, {4'b0001, 32'h7FC00000});
        add(32'hBF800000, 32'h00000000, 0, 1, {4'b0000, 32'h80000000});
        add(32'h7F7FFFFF, 32'h3F800000, 0, 0, {4'b0000, 32'h7F7FFFFF});
        add(32'h80000000, 32'h3F800000, 0, 0, {4'b0000, 32'h80000000});
        add(32'hC0000000, 32'hBF000000, 0, 0, {4'b0000, 32'h3F800000});
        drain(-1, -1, 0, 2000, 1);

        add_rand(8);
        drain(4, 8, 0, 2000, 1);

        add_rand(150);
        drain(-1, -1, 1, 5000, 1);

        add_rand(6);
        drain(-1, -1, 0, 4, 0);
        check("pre_reset_valid", bus.m_tvalid, 1);
        rst_n = 0;
        #1;
        check("mid_reset_valid", bus.m_tvalid, 0);
        check("mid_reset_quotient", bus.quotient, 0);
        check("mid_reset_flags", obs() >> 32, 0);
        sb.delete();
        pend.delete();
        held = 0;
        bus.s_tvalid = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        add(32'h40C00000, 32'h3F000000, 0, 0, {4'b0000, 32'h40400000});
        add_rand(10);
        drain(-1, -1, 0, 2000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
